// File: rtl/pmp_seq_checker_if.sv
// Request/response and PMP CSR bundle between a requester and pmp_seq_checker.
// master = requester/CSR owner side; slave = checker side.
interface pmp_seq_checker_if #(
    parameter int PMP_ENTRIES = 16,
    parameter int PA_WIDTH    = 34,
    parameter int IDX_W       = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
);
    logic                       req_valid;
    logic                       req_ready;
    logic [PA_WIDTH-1:0]        req_addr;
    logic [1:0]                 req_op;
    logic                       req_priv_m;
    logic [8*PMP_ENTRIES-1:0]   pmpcfg_i;
    logic [32*PMP_ENTRIES-1:0]  pmpaddr_i;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_allow;
    logic                       rsp_match;
    logic [IDX_W-1:0]           rsp_entry;

    modport master (
        output req_valid, req_addr, req_op, req_priv_m, pmpcfg_i, pmpaddr_i, rsp_ready,
        input  req_ready, rsp_valid, rsp_allow, rsp_match, rsp_entry
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_priv_m, pmpcfg_i, pmpaddr_i, rsp_ready,
        output req_ready, rsp_valid, rsp_allow, rsp_match, rsp_entry
    );
endinterface

// File: rtl/pmp_seq_checker.sv
// Iterative PMP checker: scans one entry per cycle in ascending order, first match wins.
// state | meaning:  S_IDLE | waiting for request;  S_SCAN | testing entry r_idx;  S_RESP | holding response
module pmp_seq_checker #(
    parameter int PMP_ENTRIES = 16,
    parameter int PA_WIDTH    = 34,
    parameter int IDX_W       = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    pmp_seq_checker_if.slave    bus
);
    localparam int AW = PA_WIDTH - 2;
    localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_EXEC = 2'd2, OP_NOTHING = 2'd3;
    localparam logic [1:0] A_OFF = 2'd0, A_TOR = 2'd1, A_NA4 = 2'd2, A_NAPOT = 2'd3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PMP_ENTRIES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic [AW-1:0]     r_addr, w_addr_nxt;
    logic [1:0]        r_op, w_op_nxt;
    logic              r_priv, w_priv_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_allow, w_allow_nxt;
    logic              r_match, w_match_nxt;
    logic [IDX_W-1:0]  r_entry, w_entry_nxt;

    logic [7:0]        w_cfg;
    logic [AW-1:0]     w_p, w_lo, w_mask;
    logic [IDX_W-1:0]  w_idx_m1;
    logic              w_hit, w_perm;

    // Entry evaluation; pmpaddr bits above AW are dropped by the size cast.
    always_comb begin
        w_idx_m1 = r_idx - 1'b1;
        w_cfg    = bus.pmpcfg_i[8*int'(r_idx) +: 8];
        w_p      = AW'(bus.pmpaddr_i[32*int'(r_idx) +: 32]);
        w_lo     = '0;
        if (r_idx != '0)
            w_lo = AW'(bus.pmpaddr_i[32*int'(w_idx_m1) +: 32]);
        // p ^ (p+1) sets the trailing ones plus the next bit; all-ones p yields mask 0.
        w_mask = ~(w_p ^ (w_p + AW'(1)));
        w_hit  = 1'b0;
        unique case (w_cfg[4:3])
            A_TOR:   w_hit = (w_lo < w_p) && (r_addr >= w_lo) && (r_addr < w_p);
            A_NA4:   w_hit = (r_addr == w_p);
            A_NAPOT: w_hit = ((r_addr & w_mask) == (w_p & w_mask));
            default: w_hit = 1'b0;
        endcase
        w_perm = 1'b0;
        if (r_priv && !w_cfg[7]) begin
            w_perm = 1'b1;
        end else begin
            unique case (r_op)
                OP_READ:  w_perm = w_cfg[0];
                OP_WRITE: w_perm = w_cfg[1] & w_cfg[0];
                OP_EXEC:  w_perm = w_cfg[2];
                default:  w_perm = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_op_nxt    = r_op;
        w_priv_nxt  = r_priv;
        w_idx_nxt   = r_idx;
        w_allow_nxt = r_allow;
        w_match_nxt = r_match;
        w_entry_nxt = r_entry;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_addr_nxt = bus.req_addr[PA_WIDTH-1:2];
                    w_op_nxt   = bus.req_op;
                    w_priv_nxt = bus.req_priv_m;
                    w_idx_nxt  = '0;
                    if (bus.req_op == OP_NOTHING) begin
                        w_allow_nxt = 1'b1;
                        w_match_nxt = 1'b0;
                        w_entry_nxt = '0;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (w_hit) begin
                    w_allow_nxt = w_perm;
                    w_match_nxt = 1'b1;
                    w_entry_nxt = r_idx;
                    w_state_nxt = S_RESP;
                end else if (r_idx == LAST_IDX) begin
                    w_allow_nxt = r_priv;
                    w_match_nxt = 1'b0;
                    w_entry_nxt = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_op    <= '0;
            r_priv  <= 1'b0;
            r_idx   <= '0;
            r_allow <= 1'b0;
            r_match <= 1'b0;
            r_entry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_op    <= w_op_nxt;
            r_priv  <= w_priv_nxt;
            r_idx   <= w_idx_nxt;
            r_allow <= w_allow_nxt;
            r_match <= w_match_nxt;
            r_entry <= w_entry_nxt;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE) && !rst;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_allow = r_allow;
    assign bus.rsp_match = r_match;
    assign bus.rsp_entry = r_entry;
endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed bench for pmp_seq_checker: expected responses queued at issue, popped when rsp_valid rises.
module tb_pmp_seq_checker;
    localparam int N   = 16;
    localparam int PAW = 34;
    localparam int IW  = 4;
    localparam logic [1:0] OP_R = 2'd0, OP_W = 2'd1, OP_X = 2'd2, OP_N = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmp_seq_checker_if #(.PMP_ENTRIES(N), .PA_WIDTH(PAW), .IDX_W(IW)) bus ();
    pmp_seq_checker #(.PMP_ENTRIES(N), .PA_WIDTH(PAW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic          allow;
        logic          match;
        logic [IW-1:0] entry;
        int            lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic [7:0] cfg, input logic [31:0] addr);
        bus.pmpcfg_i[8*i +: 8]    = cfg;
        bus.pmpaddr_i[32*i +: 32] = addr;
    endtask

    task automatic clear_pmp();
        bus.pmpcfg_i  = '0;
        bus.pmpaddr_i = '0;
    endtask

    task automatic issue(input logic [PAW-1:0] addr, input logic [1:0] op, input logic priv);
        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_op     = op;
        bus.req_priv_m = priv;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_and_check(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 40);
        cur = sb.pop_front();
        chk({tag, "_latency"}, 64'(n), 64'(cur.lat));
        chk({tag, "_allow"}, 64'(bus.rsp_allow), 64'(cur.allow));
        chk({tag, "_match"}, 64'(bus.rsp_match), 64'(cur.match));
        chk({tag, "_entry"}, 64'(bus.rsp_entry), 64'(cur.entry));
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_after_ack", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic do_req(input string tag, input logic [PAW-1:0] addr, input logic [1:0] op,
                          input logic priv, input logic allow, input logic match,
                          input logic [IW-1:0] entry, input int lat);
        exp_t e;
        e.allow = allow;
        e.match = match;
        e.entry = entry;
        e.lat   = lat;
        sb.push_back(e);
        issue(addr, op, priv);
        wait_and_check(tag);
        ack();
    endtask

    initial begin
        bit seen;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_op     = OP_R;
        bus.req_priv_m = 1'b0;
        bus.rsp_ready  = 1'b0;
        clear_pmp();
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_allow", 64'(bus.rsp_allow), 64'd0);
        chk("rst_rsp_match", 64'(bus.rsp_match), 64'd0);
        chk("rst_rsp_entry", 64'(bus.rsp_entry), 64'd0);
        rst = 1'b0;

        // NAPOT 0x8000_0000..0x8000_0FFF, RX, unlocked
        set_entry(0, 8'h1D, 32'h2000_01FF);
        do_req("napot_rd",   34'h0_8000_0FFC, OP_R, 1'b0, 1'b1, 1'b1, 4'd0, 2);
        do_req("napot_wr",   34'h0_8000_0FFC, OP_W, 1'b0, 1'b0, 1'b1, 4'd0, 2);
        do_req("napot_x",    34'h0_8000_0000, OP_X, 1'b0, 1'b1, 1'b1, 4'd0, 2);
        do_req("napot_miss", 34'h0_8000_1000, OP_R, 1'b0, 1'b0, 1'b0, 4'd0, 17);

        // TOR entry 3 over [0x1000_0000, 0x1000_1000)
        clear_pmp();
        set_entry(2, 8'h00, 32'h0400_0000);
        set_entry(3, 8'h0B, 32'h0400_0400);
        do_req("tor_hit",  34'h0_1000_0FFC, OP_R, 1'b0, 1'b1, 1'b1, 4'd3, 5);
        do_req("tor_low",  34'h0_0FFF_FFFC, OP_R, 1'b0, 1'b0, 1'b0, 4'd0, 17);
        do_req("tor_high", 34'h0_1000_1000, OP_W, 1'b0, 1'b0, 1'b0, 4'd0, 17);

        // Priority: NA4 at entry 1 without R shadows all-ones NAPOT RWX at entry 5
        clear_pmp();
        set_entry(1, 8'h10, 32'h0800_0000);
        set_entry(5, 8'h1F, 32'hFFFF_FFFF);
        do_req("prio_na4",   34'h0_2000_0000, OP_R, 1'b0, 1'b0, 1'b1, 4'd1, 3);
        do_req("prio_all",   34'h0_4000_0000, OP_R, 1'b0, 1'b1, 1'b1, 4'd5, 7);
        do_req("prio_all_x", 34'h3_FFFF_FFFC, OP_X, 1'b0, 1'b1, 1'b1, 4'd5, 7);

        // M-mode lock behaviour
        clear_pmp();
        set_entry(0, 8'h10, 32'h0800_0000);
        do_req("m_unlocked", 34'h0_2000_0000, OP_R, 1'b1, 1'b1, 1'b1, 4'd0, 2);
        set_entry(0, 8'h90, 32'h0800_0000);
        do_req("m_locked",   34'h0_2000_0000, OP_R, 1'b1, 1'b0, 1'b1, 4'd0, 2);
        do_req("m_nomatch",  34'h0_3000_0000, OP_W, 1'b1, 1'b1, 1'b0, 4'd0, 17);
        set_entry(0, 8'h12, 32'h0800_0000);
        do_req("w_without_r", 34'h0_2000_0000, OP_W, 1'b0, 1'b0, 1'b1, 4'd0, 2);

        // Back-pressure: response held, stray request dropped
        clear_pmp();
        set_entry(0, 8'h1D, 32'h2000_01FF);
        sb.push_back('{allow: 1'b1, match: 1'b1, entry: 4'd0, lat: 2});
        issue(34'h0_8000_0100, OP_R, 1'b0);
        wait_and_check("hold");
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = (c == 1);
            bus.req_op    = OP_N;
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_allow", 64'(bus.rsp_allow), 64'(cur.allow));
            chk("hold_entry", 64'(bus.rsp_entry), 64'(cur.entry));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        ack();
        repeat (3) begin
            @(negedge clk);
            chk("dropped_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        do_req("nothing", 34'h0_8000_0100, OP_N, 1'b0, 1'b1, 1'b0, 4'd0, 1);

        // Reset while scanning entry 3
        clear_pmp();
        issue(34'h0_0000_0100, OP_R, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_req_ready", 64'(bus.req_ready), 64'd0);
        chk("abort_allow", 64'(bus.rsp_allow), 64'd0);
        chk("abort_match", 64'(bus.rsp_match), 64'd0);
        chk("abort_entry", 64'(bus.rsp_entry), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
